id_stage_param: RTL and testbench

ID_STAGE_PARAM -- requirements
Module: id_stage_param

---
 rtl/id_stage_param.sv | 165 ++++++++++++++++
 tb/tb_id_stage_param.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_param.sv
// Instruction-decode stage: field decode, control generation, register file with
// write-back bypass, load-use stall control, branch resolution and the ID/EX register.
module id_stage_param #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int LOAD_STALL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc4,
  output logic            id_ready,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [8:0]      ex_ctrl,
  output logic [AW-1:0]   ex_rs,
  output logic [AW-1:0]   ex_rt,
  output logic [AW-1:0]   ex_rd,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rdata1,
  output logic [XLEN-1:0] ex_rdata2,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            flush_if
);

  localparam int DEPTH = 1 << AW;
  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;

  typedef enum logic {RUN, STALL} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] regs_q [DEPTH];

  logic            exValid_q;
  logic [8:0]      exCtrl_q;
  logic [AW-1:0]   exRs_q, exRt_q, exRd_q;
  logic [XLEN-1:0] exImm_q, exRdata1_q, exRdata2_q;

  logic [5:0]      op;
  logic [AW-1:0]   rsIdx, rtIdx, rdIdx;
  logic [XLEN-1:0] immExt, rdata1, rdata2;
  logic [8:0]      ctrl;
  logic            usesRt, hazard, advance, accept;

  assign op     = if_instr[31:26];
  assign rsIdx  = AW'(if_instr[25:21]);
  assign rtIdx  = AW'(if_instr[20:16]);
  assign rdIdx  = AW'(if_instr[15:11]);
  assign immExt = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};

  always_comb begin
    ctrl = 9'b00_000_0000;
    case (op)
      OP_R:    ctrl = 9'b10_000_1100;
      OP_LW:   ctrl = 9'b11_010_0001;
      OP_SW:   ctrl = 9'b00_001_0001;
      OP_BEQ:  ctrl = 9'b00_100_0010;
      default: ctrl = 9'b00_000_0000;
    endcase
  end

  // Reads see a same-cycle write-back so a value being retired is never missed.
  assign rdata1 = (rsIdx == '0) ? '0 :
                  (wb_we && wb_addr == rsIdx) ? wb_data : regs_q[rsIdx];
  assign rdata2 = (rtIdx == '0) ? '0 :
                  (wb_we && wb_addr == rtIdx) ? wb_data : regs_q[rtIdx];

  assign usesRt  = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);
  assign hazard  = if_valid && exValid_q && exCtrl_q[5] && (exRt_q != '0) &&
                   ((exRt_q == rsIdx) || (usesRt && exRt_q == rtIdx));
  assign advance  = ex_ready || !exValid_q;
  assign id_ready = advance && (state_q == RUN) && !hazard;
  assign accept   = if_valid && id_ready;

  assign br_taken  = accept && !rst && (op == OP_BEQ) && (rdata1 == rdata2);
  assign flush_if  = br_taken;
  assign br_target = if_pc4 + (immExt << 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // The hazard cycle itself inserts the first bubble; cnt holds the bubbles still owed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (hazard && advance && LOAD_STALL > 1) begin
          state_d = STALL;
          cnt_d   = 2'(LOAD_STALL - 1);
        end
      end
      STALL: begin
        if (advance) begin
          if (cnt_q == 2'd1) begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exValid_q  <= 1'b0;
      exCtrl_q   <= '0;
      exRs_q     <= '0;
      exRt_q     <= '0;
      exRd_q     <= '0;
      exImm_q    <= '0;
      exRdata1_q <= '0;
      exRdata2_q <= '0;
    end else if (advance) begin
      exValid_q  <= accept;
      exCtrl_q   <= accept ? ctrl : 9'd0;
      exRs_q     <= rsIdx;
      exRt_q     <= rtIdx;
      exRd_q     <= rdIdx;
      exImm_q    <= immExt;
      exRdata1_q <= rdata1;
      exRdata2_q <= rdata2;
    end
  end

  assign ex_valid  = exValid_q;
  assign ex_ctrl   = exCtrl_q;
  assign ex_rs     = exRs_q;
  assign ex_rt     = exRt_q;
  assign ex_rd     = exRd_q;
  assign ex_imm    = exImm_q;
  assign ex_rdata1 = exRdata1_q;
  assign ex_rdata2 = exRdata2_q;

endmodule

// File: tb/tb_id_stage_param.sv
// Self-checking bench for id_stage_param: directed scenarios plus a randomized
// run compared against a behavioural model of the decode stage.
module tb_id_stage_param;

  localparam int LS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        id_ready;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_ready;
  logic        ex_valid;
  logic [8:0]  ex_ctrl;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_imm, ex_rdata1, ex_rdata2;
  logic        br_taken;
  logic [31:0] br_target;
  logic        flush_if;

  int checks = 0;
  int failures = 0;

  id_stage_param #(.XLEN(32), .AW(5), .LOAD_STALL(LS)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4), .id_ready(id_ready),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .br_taken(br_taken), .br_target(br_target), .flush_if(flush_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 11'h020};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [8:0] ctrlFor(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1100;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0010;
      default: return 9'b0;
    endcase
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic er);
    if_valid = iv; if_instr = ins; if_pc4 = pc;
    wb_we = we; wb_addr = wa; wb_data = wd; ex_ready = er;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, itype(6'h04, 5'd0, 5'd0, 16'h0001), 32'h10, 1'b0, 5'd0, 32'h0, 1'b0);
    #3;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_ex_valid: got %0h expected 0", ex_valid); end
    checks++; if (ex_ctrl !== 9'h000) begin failures++; $display("[TB] FAIL rst_ex_ctrl: got %0h expected 0", ex_ctrl); end
    checks++; if (ex_rd !== 5'd0) begin failures++; $display("[TB] FAIL rst_ex_rd: got %0h expected 0", ex_rd); end
    checks++; if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_id_ready: got %0h expected 1", id_ready); end
    checks++; if (br_taken !== 1'b0 || flush_if !== 1'b0) begin failures++; $display("[TB] FAIL rst_branch: got %0h/%0h expected 0/0", br_taken, flush_if); end
    tick;
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    tick;
  endtask

  task automatic test_add_bypass;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234, 1'b1);
    tick;
    drive(1'b1, rtype(5'd5, 5'd0, 5'd3), 32'h4, 1'b0, 5'd0, 32'h0, 1'b1);
    #2;
    checks++; if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL add_id_ready: got %0h expected 1", id_ready); end
    tick;
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("[TB] FAIL add_ex_valid: got %0h expected 1", ex_valid); end
    checks++; if (ex_ctrl !== 9'h10C) begin failures++; $display("[TB] FAIL add_ex_ctrl: got %0h expected 10c", ex_ctrl); end
    checks++; if (ex_rdata1 !== 32'h1234) begin failures++; $display("[TB] FAIL add_rdata1: got %0h expected 1234", ex_rdata1); end
    checks++; if (ex_rdata2 !== 32'h0) begin failures++; $display("[TB] FAIL add_rdata2: got %0h expected 0", ex_rdata2); end
    checks++; if (ex_rs !== 5'd5 || ex_rd !== 5'd3) begin failures++; $display("[TB] FAIL add_fields: got rs=%0d rd=%0d expected rs=5 rd=3", ex_rs, ex_rd); end
    checks++; if (ex_imm !== 32'h1820) begin failures++; $display("[TB] FAIL add_imm: got %0h expected 1820", ex_imm); end
  endtask

  task automatic test_load_use;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 5'd1, 32'h40, 1'b1);
    tick;
    drive(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0), 32'h8, 1'b0, 5'd0, 32'h0, 1'b1);
    #2;
    checks++; if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL lw_id_ready: got %0h expected 1", id_ready); end
    tick;
    checks++; if (ex_ctrl !== 9'h1A1 || ex_valid !== 1'b1) begin failures++; $display("[TB] FAIL lw_ex: got ctrl=%0h valid=%0h expected 1a1/1", ex_ctrl, ex_valid); end
    checks++; if (ex_rt !== 5'd2 || ex_rdata1 !== 32'h40) begin failures++; $display("[TB] FAIL lw_fields: got rt=%0d rd1=%0h expected 2/40", ex_rt, ex_rdata1); end
    drive(1'b1, rtype(5'd2, 5'd2, 5'd4), 32'hC, 1'b0, 5'd0, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if (id_ready !== (k == 2)) begin failures++; $display("[TB] FAIL stall_id_ready[%0d]: got %0h expected %0h", k, id_ready, (k == 2)); end
      tick;
      checks++; if (ex_valid !== (k == 2)) begin failures++; $display("[TB] FAIL stall_ex_valid[%0d]: got %0h expected %0h", k, ex_valid, (k == 2)); end
      checks++; if (ex_ctrl !== ((k == 2) ? 9'h10C : 9'h000)) begin failures++; $display("[TB] FAIL stall_ex_ctrl[%0d]: got %0h", k, ex_ctrl); end
    end
    checks++; if (ex_rd !== 5'd4) begin failures++; $display("[TB] FAIL stall_issue_rd: got %0d expected 4", ex_rd); end
  endtask

  task automatic test_branch;
    drive(1'b1, itype(6'h04, 5'd1, 5'd1, 16'h0004), 32'h100, 1'b0, 5'd0, 32'h0, 1'b1);
    #2;
    checks++; if (br_taken !== 1'b1 || flush_if !== 1'b1) begin failures++; $display("[TB] FAIL beq_taken: got %0h/%0h expected 1/1", br_taken, flush_if); end
    checks++; if (br_target !== 32'h110) begin failures++; $display("[TB] FAIL beq_target_fwd: got %0h expected 110", br_target); end
    tick;
    checks++; if (ex_ctrl !== 9'h042) begin failures++; $display("[TB] FAIL beq_ctrl: got %0h expected 042", ex_ctrl); end
    drive(1'b1, itype(6'h04, 5'd1, 5'd1, 16'hFFFF), 32'h100, 1'b0, 5'd0, 32'h0, 1'b1);
    #2;
    checks++; if (br_target !== 32'hFC || br_taken !== 1'b1) begin failures++; $display("[TB] FAIL beq_target_back: got %0h/%0h expected fc/1", br_target, br_taken); end
    tick;
    drive(1'b1, itype(6'h04, 5'd1, 5'd0, 16'h0004), 32'h100, 1'b0, 5'd0, 32'h0, 1'b1);
    #2;
    checks++; if (br_taken !== 1'b0) begin failures++; $display("[TB] FAIL beq_not_taken: got %0h expected 0", br_taken); end
    tick;
  endtask

  task automatic test_backpressure;
    drive(1'b1, itype(6'h2B, 5'd1, 5'd5, 16'h0008), 32'h1F0, 1'b0, 5'd0, 32'h0, 1'b1);
    tick;
    checks++; if (ex_ctrl !== 9'h011 || ex_rdata2 !== 32'h1234) begin failures++; $display("[TB] FAIL sw_ex: got ctrl=%0h rd2=%0h expected 011/1234", ex_ctrl, ex_rdata2); end
    drive(1'b1, itype(6'h04, 5'd1, 5'd1, 16'h0004), 32'h200, 1'b0, 5'd0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if (id_ready !== 1'b0 || br_taken !== 1'b0) begin failures++; $display("[TB] FAIL hold_ready[%0d]: got ready=%0h br=%0h expected 0/0", k, id_ready, br_taken); end
      tick;
      checks++;
      if (ex_valid !== 1'b1 || ex_ctrl !== 9'h011 || ex_imm !== 32'h8 || ex_rdata2 !== 32'h1234) begin
        failures++; $display("[TB] FAIL hold_ex[%0d]: got v=%0h ctrl=%0h imm=%0h rd2=%0h expected 1/011/8/1234", k, ex_valid, ex_ctrl, ex_imm, ex_rdata2);
      end
    end
    ex_ready = 1'b1;
    #2;
    checks++; if (id_ready !== 1'b1 || br_taken !== 1'b1 || br_target !== 32'h210) begin failures++; $display("[TB] FAIL resume_branch: got ready=%0h br=%0h tgt=%0h expected 1/1/210", id_ready, br_taken, br_target); end
    tick;
    checks++; if (ex_ctrl !== 9'h042 || ex_imm !== 32'h4) begin failures++; $display("[TB] FAIL resume_ex: got ctrl=%0h imm=%0h expected 042/4", ex_ctrl, ex_imm); end
  endtask

  task automatic test_reset_mid_stall;
    drive(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0), 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    tick;
    drive(1'b1, rtype(5'd2, 5'd2, 5'd4), 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    #2;
    checks++; if (id_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_hazard: got %0h expected 0", id_ready); end
    tick;
    rst = 1'b1;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 9'h0 || ex_rt !== 5'd0) begin failures++; $display("[TB] FAIL mid_rst_ex: got v=%0h ctrl=%0h rt=%0d expected 0/0/0", ex_valid, ex_ctrl, ex_rt); end
    checks++; if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_rst_state: got ready=%0h expected 1", id_ready); end
    tick;
    rst = 1'b0;
    drive(1'b1, rtype(5'd5, 5'd1, 5'd3), 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    #2;
    checks++; if (id_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_rst_ready: got %0h expected 1", id_ready); end
    tick;
    checks++; if (ex_valid !== 1'b1 || ex_rdata1 !== 32'h0 || ex_rdata2 !== 32'h0) begin failures++; $display("[TB] FAIL post_rst_regs: got v=%0h rd1=%0h rd2=%0h expected 1/0/0", ex_valid, ex_rdata1, ex_rdata2); end
  endtask

  task automatic test_r0_and_bypass;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 5'd7, 32'h55, 1'b1);
    tick;
    drive(1'b1, rtype(5'd0, 5'd7, 5'd3), 32'h0, 1'b1, 5'd0, 32'hFFFF, 1'b1);
    tick;
    checks++; if (ex_rdata1 !== 32'h0 || ex_rdata2 !== 32'h55) begin failures++; $display("[TB] FAIL r0_write: got rd1=%0h rd2=%0h expected 0/55", ex_rdata1, ex_rdata2); end
    drive(1'b1, itype(6'h04, 5'd7, 5'd0, 16'h0002), 32'h300, 1'b1, 5'd7, 32'h0, 1'b1);
    #2;
    checks++; if (br_taken !== 1'b1 || br_target !== 32'h308) begin failures++; $display("[TB] FAIL bypass_beq: got br=%0h tgt=%0h expected 1/308", br_taken, br_target); end
    tick;
    checks++; if (ex_rdata1 !== 32'h0) begin failures++; $display("[TB] FAIL bypass_rdata: got %0h expected 0", ex_rdata1); end
  endtask

  task automatic test_random;
    logic [31:0] mRegs [32];
    logic        mValid;
    logic [8:0]  mCtrl;
    logic [5:0]  mOp;
    logic [4:0]  mRs, mRt, mRd;
    logic [31:0] mImm, mR1, mR2;
    int          owed;
    logic        iv, er, we, hold, hz, adv, rdy, taken, usesRt;
    logic [31:0] ins, pc, wd, r1, r2, tgt;
    logic [4:0]  wa, rs, rt;
    logic [5:0]  op;
    logic signed [31:0] simm;
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
    mValid = 1'b0; mCtrl = 9'h0; mOp = 6'h3F; mRs = 0; mRt = 0; mRd = 0;
    mImm = 0; mR1 = 0; mR2 = 0; owed = 0; hold = 1'b0; ins = 32'h0; iv = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        case ($urandom_range(0, 4))
          0: op = 6'h00;
          1: op = 6'h23;
          2: op = 6'h2B;
          3: op = 6'h04;
          default: op = 6'($urandom_range(0, 63));
        endcase
        ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
        iv = ($urandom_range(0, 9) < 8);
      end
      er = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1) == 1;
      wa = 5'($urandom_range(0, 7));
      wd = $urandom;
      pc = $urandom & 32'hFFFF_FFFC;
      drive(iv, ins, pc, we, wa, wd, er);
      #2;
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
      r1 = (rs == 0) ? 32'h0 : (we && wa == rs) ? wd : mRegs[rs];
      r2 = (rt == 0) ? 32'h0 : (we && wa == rt) ? wd : mRegs[rt];
      usesRt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
      hz = iv && mValid && mOp == 6'h23 && mRt != 0 && (mRt == rs || (usesRt && mRt == rt));
      adv = er || !mValid;
      rdy = adv && owed == 0 && !hz;
      taken = iv && rdy && op == 6'h04 && r1 == r2;
      simm = $signed(ins[15:0]);
      tgt = pc + 32'(simm * 4);
      checks++; if (id_ready !== rdy) begin failures++; $display("[TB] FAIL rnd_id_ready@%0d: got %0h expected %0h", c, id_ready, rdy); end
      checks++; if (br_taken !== taken || flush_if !== taken) begin failures++; $display("[TB] FAIL rnd_br_taken@%0d: got %0h/%0h expected %0h", c, br_taken, flush_if, taken); end
      if (op == 6'h04) begin
        checks++; if (br_target !== tgt) begin failures++; $display("[TB] FAIL rnd_br_target@%0d: got %0h expected %0h", c, br_target, tgt); end
      end
      if (adv) begin
        mValid = iv && rdy;
        mCtrl = mValid ? ctrlFor(op) : 9'h0;
        mOp = mValid ? op : 6'h3F;
        mRs = rs; mRt = rt; mRd = ins[15:11];
        mImm = 32'(simm); mR1 = r1; mR2 = r2;
        if (hz) owed = LS - 1;
        else if (owed > 0) owed--;
      end
      if (we && wa != 0) mRegs[wa] = wd;
      hold = iv && !rdy;
      tick;
      checks++; if (ex_valid !== mValid || ex_ctrl !== mCtrl) begin failures++; $display("[TB] FAIL rnd_ex_ctrl@%0d: got v=%0h ctrl=%0h expected v=%0h ctrl=%0h", c, ex_valid, ex_ctrl, mValid, mCtrl); end
      if (mValid) begin
        checks++;
        if (ex_rs !== mRs || ex_rt !== mRt || ex_rd !== mRd || ex_imm !== mImm || ex_rdata1 !== mR1 || ex_rdata2 !== mR2) begin
          failures++;
          $display("[TB] FAIL rnd_ex_fields@%0d: got %0d %0d %0d %0h %0h %0h expected %0d %0d %0d %0h %0h %0h", c,
                   ex_rs, ex_rt, ex_rd, ex_imm, ex_rdata1, ex_rdata2, mRs, mRt, mRd, mImm, mR1, mR2);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_bypass();
    test_load_use();
    test_branch();
    test_backpressure();
    test_reset_mid_stall();
    test_r0_and_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
